// File: rtl/tiny_world_pkg.sv
// Shared island geometry and scheduler state encoding for the tiny-world video/game blocks.
package tiny_world_pkg;

  localparam int LEFT_EDGE     = 128;
  localparam int RIGHT_EDGE    = 896;
  localparam int TOP_EDGE      = 96;
  localparam int BOTTOM_EDGE   = 672;
  localparam int ISLAND_WIDTH  = 96;
  localparam int ISLAND_HEIGHT = 72;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DISP  = 2'd2
  } sched_state_t;

  function automatic logic on_display_line(input logic [9:0] v);
    return (v >= 10'(TOP_EDGE)) && (v < 10'(BOTTOM_EDGE));
  endfunction

endpackage

// File: rtl/people_mem_sched_if.sv
// Update-engine request/grant and read-return bundle of the people BRAM scheduler.
interface people_mem_sched_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 30
);
  logic              upd_req;
  logic              upd_we;
  logic [ADDR_W-1:0] upd_addr;
  logic [DATA_W-1:0] upd_wdata;
  logic              upd_gnt;
  logic              upd_rvalid;
  logic [DATA_W-1:0] upd_rdata;

  modport master (
    output upd_req, upd_we, upd_addr, upd_wdata,
    input  upd_gnt, upd_rvalid, upd_rdata
  );

  modport slave (
    input  upd_req, upd_we, upd_addr, upd_wdata,
    output upd_gnt, upd_rvalid, upd_rdata
  );
endinterface

// File: rtl/people_mem_sched_rd_valid_pipe.sv
// Read-return tracker: carries a granted read's valid bit and out-of-range flag for LAT cycles.
module rd_valid_pipe #(
  parameter int LAT = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic in_valid,
  input  logic in_oor,
  output logic out_valid,
  output logic out_oor
);

  logic [LAT-1:0] valid_r;
  logic [LAT-1:0] oor_r;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_r <= '0;
      oor_r   <= '0;
    end else begin
      valid_r[0] <= in_valid;
      oor_r[0]   <= in_oor;
      for (int i = 1; i < LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        oor_r[i]   <= oor_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[LAT-1];
  assign out_oor   = oor_r[LAT-1];

endmodule

// File: rtl/people_mem_sched.sv
// Time-shares the single-port people BRAM between the display path and the update engine.
// Optional stall statistics (upd_stall_max) are built when PEOPLE_SCHED_STATS_EN is defined.
module people_mem_sched
  import tiny_world_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 30,
  parameter int BRAM_LAT = 2,
  parameter int NCELLS   = 6912,
  parameter int GUARD    = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  people_mem_sched_if.slave upd,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
`ifdef PEOPLE_SCHED_STATS_EN
  ,
  output logic [10:0]       upd_stall_max
`endif
);

  localparam logic [10:0] H_GUARD = 11'(LEFT_EDGE - 2 * GUARD);
  localparam logic [10:0] H_DISP  = 11'(LEFT_EDGE - GUARD);
  localparam logic [10:0] H_END   = 11'(RIGHT_EDGE);

  sched_state_t state_r, state_s;
  logic         disp_line_s;
  logic         oor_s;
  logic         gnt_s;
  logic         rd_s;
  logic         pipe_valid_s;
  logic         pipe_oor_s;

  assign disp_line_s = on_display_line(vcount);
  assign oor_s       = (upd.upd_addr >= ADDR_W'(NCELLS));

  // Transitions take effect in the cycle their hcount is seen, so the FREE->GUARD cycle already refuses grants.
  always_comb begin
    state_s = ST_FREE;
    case (state_r)
      ST_FREE: begin
        if (disp_line_s && (hcount == H_GUARD)) state_s = ST_GUARD;
        else                                    state_s = ST_FREE;
      end
      ST_GUARD: begin
        if (!disp_line_s)            state_s = ST_FREE;
        else if (hcount == H_DISP)   state_s = ST_DISP;
        else                         state_s = ST_GUARD;
      end
      ST_DISP: begin
        if (!disp_line_s || (hcount == H_END)) state_s = ST_FREE;
        else                                   state_s = ST_DISP;
      end
      default: state_s = ST_FREE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_r <= ST_FREE;
    else         state_r <= state_s;
  end

  always_comb begin
    gnt_s     = 1'b0;
    rd_s      = 1'b0;
    bram_addr = '0;
    bram_we   = 1'b0;
    bram_din  = '0;
    if (!rst_in) begin
      bram_addr = '0;
    end else if ((state_s == ST_FREE) && upd.upd_req) begin
      gnt_s     = 1'b1;
      rd_s      = !upd.upd_we;
      bram_addr = upd.upd_addr;
      bram_we   = upd.upd_we && !oor_s;
      bram_din  = upd.upd_wdata;
    end else begin
      bram_addr = disp_addr;
    end
  end

  rd_valid_pipe #(.LAT(BRAM_LAT)) u_rd_pipe (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .in_valid  (rd_s),
    .in_oor    (oor_s),
    .out_valid (pipe_valid_s),
    .out_oor   (pipe_oor_s)
  );

  always_comb begin
    if (pipe_valid_s && !pipe_oor_s && rst_in) upd.upd_rdata = bram_dout;
    else                                       upd.upd_rdata = '0;
  end

  assign upd.upd_gnt    = gnt_s;
  assign upd.upd_rvalid = pipe_valid_s;
  assign disp_data      = bram_dout;

`ifdef PEOPLE_SCHED_STATS_EN
  logic [10:0] stall_run_r;
  logic [10:0] stall_max_r;
  logic [10:0] run_inc_s;

  assign run_inc_s = (stall_run_r == 11'h7FF) ? stall_run_r : stall_run_r + 11'd1;

  // Longest waiting run since the start of the current frame, saturating at the counter width.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stall_run_r <= 11'd0;
      stall_max_r <= 11'd0;
    end else if ((vcount == 10'd0) && (hcount == 11'd0)) begin
      stall_run_r <= 11'd0;
      stall_max_r <= 11'd0;
    end else if (upd.upd_req && !gnt_s) begin
      stall_run_r <= run_inc_s;
      if (run_inc_s > stall_max_r) stall_max_r <= run_inc_s;
      else                         stall_max_r <= stall_max_r;
    end else begin
      stall_run_r <= 11'd0;
    end
  end

  assign upd_stall_max = stall_max_r;
`endif

endmodule

// File: tb/tb_people_mem_sched.sv
// Randomized bench for people_mem_sched with a raster-level reference model and a BRAM model.
module tb_people_mem_sched;

  localparam int GUARD = 4;
  localparam int LAT   = 2;
  localparam int NC    = 6912;

  typedef struct {
    int          due;
    logic [29:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [12:0] disp_addr;
  logic [29:0] disp_data;
  logic [12:0] bram_addr;
  logic        bram_we;
  logic [29:0] bram_din;
  logic [29:0] bram_q1 = 30'd0;
  logic [29:0] bram_dout = 30'd0;
`ifdef PEOPLE_SCHED_STATS_EN
  logic [10:0] stall_max;
`endif

  logic [29:0] mem    [8192];
  logic [29:0] shadow [8192];
  rd_t         rq[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   rand_en = 1'b0;
  logic gnt_q = 1'b0;
  logic got;

  people_mem_sched_if #(.ADDR_W(13), .DATA_W(30)) upd();

  always #5 clk = ~clk;

  people_mem_sched #(
    .ADDR_W(13), .DATA_W(30), .BRAM_LAT(LAT), .NCELLS(NC), .GUARD(GUARD)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst_n),
    .hcount    (hcount),
    .vcount    (vcount),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .upd       (upd),
    .bram_addr (bram_addr),
    .bram_we   (bram_we),
    .bram_din  (bram_din),
    .bram_dout (bram_dout)
`ifdef PEOPLE_SCHED_STATS_EN
    ,
    .upd_stall_max (stall_max)
`endif
  );

  // Two-cycle-latency single-port BRAM
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    bram_q1   <= mem[bram_addr];
    bram_dout <= bram_q1;
  end

  function automatic logic [29:0] init_word(input int i);
    logic [12:0] a;
    a = 13'(i);
    return {a, 17'h0A5A5};
  endfunction

  // Grants are refused from GUARD cycles before the window opens until the right edge.
  function automatic bit model_free(input int h, input int v);
    if (v < 96 || v >= 672) return 1'b1;
    return !(h >= 128 - 2 * GUARD && h < 896);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (h=%0d v=%0d cyc=%0d)", name, act, exp, hcount, vcount, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit  free_c, eg, oor;
    rd_t it;
    if (!rst_n) begin
      rq.delete();
      check("rst_gnt",       32'(upd.upd_gnt),    32'd0);
      check("rst_rvalid",    32'(upd.upd_rvalid), 32'd0);
      check("rst_rdata",     32'(upd.upd_rdata),  32'd0);
      check("rst_bram_we",   32'(bram_we),        32'd0);
      check("rst_bram_addr", 32'(bram_addr),      32'd0);
      check("rst_bram_din",  32'(bram_din),       32'd0);
    end else begin
      free_c = model_free(int'(hcount), int'(vcount));
      eg     = upd.upd_req && free_c;
      oor    = (int'(upd.upd_addr) >= NC);
      check("gnt",       32'(upd.upd_gnt), 32'(eg));
      check("bram_addr", 32'(bram_addr),   eg ? 32'(upd.upd_addr) : 32'(disp_addr));
      check("bram_we",   32'(bram_we),     32'(eg && upd.upd_we && !oor));
      if (eg && upd.upd_we && !oor) check("bram_din", 32'(bram_din), 32'(upd.upd_wdata));
      if (rq.size() > 0 && rq[0].due == cyc) begin
        check("rvalid", 32'(upd.upd_rvalid), 32'd1);
        check("rdata",  32'(upd.upd_rdata),  32'(rq[0].data));
        rq.delete(0);
      end else begin
        check("rvalid", 32'(upd.upd_rvalid), 32'd0);
      end
      if (eg && !upd.upd_we) begin
        it.due  = cyc + LAT;
        it.data = oor ? 30'd0 : shadow[upd.upd_addr];
        rq.push_back(it);
      end
      if (eg && upd.upd_we && !oor) shadow[upd.upd_addr] = upd.upd_wdata;
      check("disp_data", 32'(disp_data), 32'(bram_dout));
    end
    gnt_q = upd.upd_gnt;
    cyc++;
  end

  // The engine holds an ungranted request; otherwise it may issue a fresh random one.
  task automatic drive_engine();
    if (rand_en && !(upd.upd_req && !gnt_q)) begin
      upd.upd_req   = ($urandom_range(0, 3) != 0);
      upd.upd_we    = 1'($urandom_range(0, 1));
      upd.upd_addr  = ($urandom_range(0, 7) == 0) ? 13'($urandom_range(NC, 8191))
                                                  : 13'($urandom_range(0, NC - 1));
      upd.upd_wdata = 30'($urandom);
    end
  endtask

  task automatic adv(input bit jmp, input int jh, input int jv);
    @(posedge clk);
    #1;
    if (jmp) begin
      hcount = 11'(jh);
      vcount = 10'(jv);
    end else if (hcount == 11'd1343) begin
      hcount = 11'd0;
      vcount = (vcount == 10'd805) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount = hcount + 11'd1;
    end
    disp_addr = 13'($urandom_range(0, 8191));
    drive_engine();
  endtask

  task automatic tick();
    adv(1'b0, 0, 0);
  endtask

  task automatic jump_to(input int h, input int v);
    adv(1'b1, h, v);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    rst_n         = 1'b0;
    hcount        = 11'd994;
    vcount        = 10'd100;
    disp_addr     = 13'h1234;
    upd.upd_req   = 1'b1;
    upd.upd_we    = 1'b1;
    upd.upd_addr  = 13'd77;
    upd.upd_wdata = 30'h3FFFFFFF;

    @(negedge clk);
    check("reset_gnt_lit",  32'(upd.upd_gnt), 32'd0);
    check("reset_addr_lit", 32'(bram_addr),   32'd0);
    tick();
    tick();
    upd.upd_req = 1'b0;
    rst_n       = 1'b1;
    repeat (4) tick();

    // Blanking read of word 5 at hcount 1000
    upd.upd_req  = 1'b1;
    upd.upd_we   = 1'b0;
    upd.upd_addr = 13'd5;
    @(negedge clk);
    check("blank_h", 32'(hcount), 32'd1000);
    check("blank_gnt", 32'(upd.upd_gnt), 32'd1);
    tick();
    upd.upd_req = 1'b0;
    tick();
    @(negedge clk);
    check("blank_rvalid", 32'(upd.upd_rvalid), 32'd1);
    check("blank_rdata",  32'(upd.upd_rdata),  32'h000AA5A5);

    // Out-of-range write, then out-of-range read
    tick();
    upd.upd_req   = 1'b1;
    upd.upd_we    = 1'b1;
    upd.upd_addr  = 13'd7000;
    upd.upd_wdata = 30'h15555555;
    @(negedge clk);
    check("oor_gnt", 32'(upd.upd_gnt), 32'd1);
    check("oor_we",  32'(bram_we),     32'd0);
    tick();
    upd.upd_we = 1'b0;
    tick();
    upd.upd_req = 1'b0;
    tick();
    @(negedge clk);
    check("oor_rvalid", 32'(upd.upd_rvalid), 32'd1);
    check("oor_rdata",  32'(upd.upd_rdata),  32'd0);

    // Guard boundary on a display line
    jump_to(119, 100);
    upd.upd_req  = 1'b1;
    upd.upd_we   = 1'b0;
    upd.upd_addr = 13'd6;
    @(negedge clk);
    check("h119_gnt", 32'(upd.upd_gnt), 32'd1);
    tick();
    upd.upd_addr = 13'd7;
    @(negedge clk);
    check("h120_gnt", 32'(upd.upd_gnt), 32'd0);
    tick();
    @(negedge clk);
    check("h121_rvalid", 32'(upd.upd_rvalid), 32'd1);
    check("h121_rdata",  32'(upd.upd_rdata),  32'h000CA5A5);
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      tick();
      @(negedge clk);
      got = upd.upd_gnt;
    end
    check("disp_wait_gnt", 32'(got),    32'd1);
    check("disp_gnt_h",    32'(hcount), 32'd896);
    tick();
    upd.upd_req = 1'b0;

    // Random traffic across several display lines
    rand_en = 1'b1;
    for (int i = 0; i < 3000; i++) tick();
    rand_en = 1'b0;
    for (int i = 0; i < 2000 && upd.upd_req && !gnt_q; i++) tick();
    upd.upd_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      tick();
      got = (hcount >= 11'd900) && (hcount <= 11'd1200);
    end
    check("reach_blank", 32'(got), 32'd1);

    // Reset one cycle after a read grant
    upd.upd_req  = 1'b1;
    upd.upd_we   = 1'b0;
    upd.upd_addr = 13'd9;
    @(negedge clk);
    check("pre_rst_gnt", 32'(upd.upd_gnt), 32'd1);
    tick();
    upd.upd_req = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    check("rst_mid_rvalid1", 32'(upd.upd_rvalid), 32'd0);
    tick();
    @(negedge clk);
    check("rst_mid_rvalid2", 32'(upd.upd_rvalid), 32'd0);
    check("rst_mid_rdata",   32'(upd.upd_rdata),  32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("post_rst_rvalid", 32'(upd.upd_rvalid), 32'd0);
    end

`ifdef PEOPLE_SCHED_STATS_EN
    // Request held across a full display line: refused in GUARD and the display window
    jump_to(1000, 100);
    upd.upd_req  = 1'b1;
    upd.upd_we   = 1'b0;
    upd.upd_addr = 13'd1;
    for (int i = 0; i < 1344; i++) tick();
    upd.upd_req = 1'b0;
    @(negedge clk);
    check("stall_max", 32'(stall_max), 32'(GUARD + (896 - (128 - GUARD))));
    jump_to(1342, 805);
    tick();
    tick();
    tick();
    @(negedge clk);
    check("stall_clear", 32'(stall_max), 32'd0);
`endif

    repeat (4) tick();
    check("oor_word_kept", 32'(mem[7000]), 32'(init_word(7000)));
    check("reads_drained", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
